eth_tx: RTL
===========

Name: eth_tx

Overview:
- Ethernet frame transmitter; the transmit-side counterpart of eth_rx.
- Takes a payload byte stream from upstream (UART-to-net bridge or decision serializer) and emits one byte per cycle on a MII-like byte interface.
- Each frame is preamble, SFD, MAC header, payload (padded to the minimum length), CRC-32 FCS, then the inter-frame gap.
- Output is directly loopback-compatible with the eth_rx rx_byte/rx_valid input.

Parameters:
- MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded.
- MAX_PAYLOAD, 1500, maximum payload bytes; beyond this the frame is closed and the rest of the input is dropped.
- IFG_CYCLES, 12, idle cycles forced after every frame, including aborted ones.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cfg_dst_mac  in  48  destination MAC, MSB byte sent first; sampled at frame start
- cfg_src_mac  in  48  source MAC, MSB byte sent first; sampled at frame start
- cfg_ethertype  in  16  EtherType, MSB byte first; sampled at frame start
- s_byte  in  8  payload byte
- s_valid  in  1  s_byte valid
- s_last  in  1  marks the final payload byte
- s_ready  out  1  payload byte accepted when s_valid && s_ready
- tx_byte  out  8  line byte
- tx_valid  out  1  tx_byte valid; continuous for the whole frame
- tx_err  out  1  one-cycle abort marker
- busy  out  1  high whenever state != IDLE
- stat_underrun  out  1  one-cycle pulse on underrun abort
- stat_oversize  out  1  one-cycle pulse on oversize truncation
- frames_sent  out  32  count of completed good frames; wraps

Behaviour:
- Reset: state=IDLE; tx_byte=0, tx_valid=0, tx_err=0, s_ready=0, busy=0, stat_*=0, frames_sent=0. Reset mid-frame ends the frame immediately, with no FCS and no IFG.
- All line outputs are registered.
- States: IDLE → PREAMBLE → SFD → HDR → PAYLOAD → PAD → FCS → IFG → IDLE. Side states ABORT and DRAIN.
- IDLE:
  - On s_valid=1, latch the cfg_* inputs, init CRC to 0xFFFFFFFF, go to PREAMBLE.
  - The first 0x55 appears on tx_byte the next cycle.
  - s_ready=0 in IDLE.
- PREAMBLE / SFD / HDR:
  - PREAMBLE: 7 × 0x55.
  - SFD: 0xD5.
  - HDR: 14 bytes (dst[47:40]…dst[7:0], src…, type[15:8], type[7:0]).
  - CRC is not updated during preamble/SFD; it covers HDR through PAD.
- PAYLOAD:
  - s_ready=1 (combinational from state).
  - An accepted byte appears on tx_byte exactly 1 cycle later; pay_cnt increments.
  - Accepted with s_last:
    - pay_cnt after the byte < MIN_PAYLOAD → PAD.
    - Otherwise → FCS.
  - Byte number MAX_PAYLOAD accepted without s_last → FCS; pulse stat_oversize; DRAIN after FCS.
  - s_valid=0 in PAYLOAD is an underrun → ABORT.
- PAD: emit 0x00 until pay_cnt == MIN_PAYLOAD; s_ready=0.
- FCS:
  - Emit ~crc, LSB byte first (crc[7:0] first).
  - CRC-32 reflected, poly 0xEDB88320, init 0xFFFFFFFF.
  - Afterwards: increment frames_sent (good frames only, not truncated ones), then go to IFG, or to DRAIN if truncated.
- ABORT:
  - One cycle: tx_valid=0, tx_err=1, stat_underrun=1.
  - Then go to DRAIN, or straight to IFG if the last byte was already seen.
  - frames_sent is not incremented.
- DRAIN:
  - tx_valid=0, s_ready=1; discard bytes until one accepted with s_last, then go to IFG.
  - s_last accepted the same cycle DRAIN is entered is honoured.
- IFG:
  - IFG_CYCLES cycles with tx_valid=0 and s_ready=0, then IDLE.
  - s_valid held high during IFG starts the next frame on the first IDLE cycle.
- tx_valid is never low between the first preamble byte and the last FCS byte of a good frame.
- pay_cnt width is $clog2(MAX_PAYLOAD+1).

Decomposition:
- Package eth_pkg holds:
  - State enum.
  - Constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3, PREAMBLE_LEN=7, HDR_LEN=14.
  - eth_rx imports the same package.
- Sub-module: eth_crc32_d8, a combinational one-byte CRC step (crc_in, data → crc_out), shared with eth_rx.

Test Plan:
- Minimum frame: dst=FF:FF:FF:FF:FF:FF, src=02:00:00:00:00:01, type=0x88B5, single byte 0xAB with s_last → 72 contiguous tx_valid cycles (8 + 14 + 1 + 45 pad + 4). FCS matches the software CRC model. Loopback into eth_rx gives crc_ok=1 and payload 0xAB followed by 45 zeros.
- 60-byte payload 0x00..0x3B, no pad → 86 tx_valid cycles, no PAD state, frames_sent=1. Next frame's s_valid held during IFG → exactly 12 idle cycles between frames.
- Underrun: s_valid drops after payload byte 10 → tx_valid falls, tx_err=1 and stat_underrun=1 for 1 cycle. Input drained through s_last, then 12-cycle IFG; frames_sent unchanged.
- Oversize with MAX_PAYLOAD=64: 80-byte stream → 64 payload bytes + FCS on the line, stat_oversize pulse. Remaining 16 bytes accepted and dropped, frames_sent unchanged.
- rst=1 asserted mid-HDR → next cycle tx_valid=0, busy=0, s_ready=0; a new frame started afterwards is bit-exact with the first scenario.
- Back-to-back 100 random frames (lengths 1..MAX_PAYLOAD) looped into eth_rx → all crc_ok=1, payloads match, frames_sent=100.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: frame FSM states, line constants and CRC-32 parameters.
package eth_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_HDR,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_ABORT,
    ST_DRAIN
  } eth_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam int          PREAMBLE_LEN  = 7;
  localparam int          HDR_LEN       = 14;

endpackage

// File: rtl/eth_crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32 (LSB of the byte enters first).
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_tx.sv
// Ethernet frame transmitter: preamble, SFD, MAC header, padded payload, FCS and
// inter-frame gap, one registered byte per cycle on an MII-like byte interface.
module eth_tx
  import eth_pkg::*;
#(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500,
  parameter int IFG_CYCLES  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] cfg_dst_mac,
  input  logic [47:0] cfg_src_mac,
  input  logic [15:0] cfg_ethertype,
  input  logic [7:0]  s_byte,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  output logic        tx_err,
  output logic        busy,
  output logic        stat_underrun,
  output logic        stat_oversize,
  output logic [31:0] frames_sent
);

  localparam int PAY_W = $clog2(MAX_PAYLOAD + 1);
  localparam int CNT_W = $clog2(IFG_CYCLES + HDR_LEN);

  eth_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PAY_W-1:0]     pay_cnt_q, pay_cnt_d, pay_cnt_inc;
  logic [8*HDR_LEN-1:0] hdr_q, hdr_d;
  logic [31:0]          crc_q, crc_d, crc_step;
  logic                 trunc_q, trunc_d, last_seen_q, last_seen_d;
  logic [31:0]          frames_q, frames_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 tx_valid_q, tx_valid_d, tx_err_q, tx_err_d;
  logic                 underrun_q, underrun_d, oversize_q, oversize_d;
  logic                 crc_en, accept;

  assign s_ready     = (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);
  assign accept      = s_valid && s_ready;
  assign pay_cnt_inc = pay_cnt_q + 1'b1;

  // The CRC always folds in the byte being loaded into the line register.
  eth_crc32_d8 u_crc (
    .crc_in (crc_q),
    .data   (tx_byte_d),
    .crc_out(crc_step)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pay_cnt_q   <= '0;
      hdr_q       <= '0;
      crc_q       <= '0;
      trunc_q     <= 1'b0;
      last_seen_q <= 1'b0;
      frames_q    <= '0;
      tx_byte_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_err_q    <= 1'b0;
      underrun_q  <= 1'b0;
      oversize_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      hdr_q       <= hdr_d;
      crc_q       <= crc_d;
      trunc_q     <= trunc_d;
      last_seen_q <= last_seen_d;
      frames_q    <= frames_d;
      tx_byte_q   <= tx_byte_d;
      tx_valid_q  <= tx_valid_d;
      tx_err_q    <= tx_err_d;
      underrun_q  <= underrun_d;
      oversize_q  <= oversize_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can leave one
    // unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pay_cnt_d   = pay_cnt_q;
    hdr_d       = hdr_q;
    crc_d       = crc_en ? crc_step : crc_q;
    trunc_d     = trunc_q;
    last_seen_d = last_seen_q | (accept & s_last);
    frames_d    = frames_q;
    unique case (state_q)
      ST_IDLE: if (s_valid) begin
        state_d     = ST_PREAMBLE;
        cnt_d       = CNT_W'(1);
        pay_cnt_d   = '0;
        hdr_d       = {cfg_dst_mac, cfg_src_mac, cfg_ethertype};
        crc_d       = CRC_INIT;
        trunc_d     = 1'b0;
        last_seen_d = 1'b0;
      end
      ST_PREAMBLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
          state_d = ST_SFD;
          cnt_d   = '0;
        end
      end
      ST_SFD: state_d = ST_HDR;
      ST_HDR: begin
        hdr_d = hdr_q << 8;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(HDR_LEN - 1)) begin
          state_d = ST_PAYLOAD;
          cnt_d   = '0;
        end
      end
      ST_PAYLOAD: begin
        if (!s_valid) begin
          state_d = ST_ABORT;
        end else begin
          pay_cnt_d = pay_cnt_inc;
          if (s_last) begin
            state_d = (pay_cnt_inc < PAY_W'(MIN_PAYLOAD)) ? ST_PAD : ST_FCS;
          end else if (pay_cnt_inc == PAY_W'(MAX_PAYLOAD)) begin
            state_d = ST_FCS;
            trunc_d = 1'b1;
          end
        end
      end
      ST_PAD: begin
        pay_cnt_d = pay_cnt_inc;
        if (pay_cnt_inc >= PAY_W'(MIN_PAYLOAD)) state_d = ST_FCS;
      end
      ST_FCS: begin
        crc_d = {8'h00, crc_q[31:8]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(3)) begin
          cnt_d = '0;
          if (trunc_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d  = ST_IFG;
            frames_d = frames_q + 1'b1;
          end
        end
      end
      ST_ABORT: begin
        state_d = last_seen_q ? ST_IFG : ST_DRAIN;
        cnt_d   = '0;
      end
      ST_DRAIN: if (accept && s_last) begin
        state_d = ST_IFG;
        cnt_d   = '0;
      end
      ST_IFG: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(IFG_CYCLES - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line outputs are computed one cycle ahead and land in the output registers.
  always_comb begin
    tx_byte_d  = '0;
    tx_valid_d = 1'b0;
    tx_err_d   = 1'b0;
    underrun_d = 1'b0;
    oversize_d = 1'b0;
    crc_en     = 1'b0;
    case (state_q)
      ST_IDLE: if (s_valid) begin
        tx_byte_d  = PREAMBLE_BYTE;
        tx_valid_d = 1'b1;
      end
      ST_PREAMBLE: begin
        tx_byte_d  = PREAMBLE_BYTE;
        tx_valid_d = 1'b1;
      end
      ST_SFD: begin
        tx_byte_d  = SFD_BYTE;
        tx_valid_d = 1'b1;
      end
      ST_HDR: begin
        tx_byte_d  = hdr_q[8*HDR_LEN-1 -: 8];
        tx_valid_d = 1'b1;
        crc_en     = 1'b1;
      end
      ST_PAYLOAD: begin
        if (s_valid) begin
          tx_byte_d  = s_byte;
          tx_valid_d = 1'b1;
          crc_en     = 1'b1;
          oversize_d = !s_last && (pay_cnt_inc == PAY_W'(MAX_PAYLOAD));
        end else begin
          tx_err_d   = 1'b1;
          underrun_d = 1'b1;
        end
      end
      ST_PAD: begin
        tx_valid_d = 1'b1;
        crc_en     = 1'b1;
      end
      ST_FCS: begin
        tx_byte_d  = ~crc_q[7:0];
        tx_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign tx_byte       = tx_byte_q;
  assign tx_valid      = tx_valid_q;
  assign tx_err        = tx_err_q;
  assign stat_underrun = underrun_q;
  assign stat_oversize = oversize_q;
  assign frames_sent   = frames_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
